// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: routes a serial stream into four lane registers, presenting complete frames.
// Optional lock-loss idle timer enabled by defining TDM_DEMUX_LOSS_EN.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             address0,
  output logic             address1,
  output logic             frame_valid,
  output logic             sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] shadow0;
  logic [WIDTH-1:0] shadow1;
  logic [WIDTH-1:0] shadow2;
`ifdef TDM_DEMUX_LOSS_EN
  logic [3:0]       idle_cnt;
`endif

  // slot is the next slot to be filled; the address pins expose it directly
  assign address0 = slot[0];
  assign address1 = slot[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      slot        <= 2'd0;
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_DEMUX_LOSS_EN
      idle_cnt    <= 4'd0;
`endif
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (in_valid) begin
`ifdef TDM_DEMUX_LOSS_EN
        idle_cnt <= 4'd0;
`endif
        if (state == HUNT) begin
          if (in_sync) begin
            shadow0 <= in_data;
            slot    <= 2'd1;
            state   <= LOCKED;
          end
        end else if (in_sync && slot != 2'd0) begin
          // Resync drops the partial frame and restarts it with this sample
          sync_err <= 1'b1;
          shadow0  <= in_data;
          slot     <= 2'd1;
        end else begin
          case (slot)
            2'd0: shadow0 <= in_data;
            2'd1: shadow1 <= in_data;
            2'd2: shadow2 <= in_data;
            default: begin
              out0        <= shadow0;
              out1        <= shadow1;
              out2        <= shadow2;
              out3        <= in_data;
              frame_valid <= 1'b1;
            end
          endcase
          slot <= slot + 2'd1;
        end
      end
`ifdef TDM_DEMUX_LOSS_EN
      else if (state == LOCKED) begin
        // The 15th consecutive idle cycle is the edge where the count would reach 15
        if (idle_cnt == 4'd14) begin
          sync_err <= 1'b1;
          state    <= HUNT;
          slot     <= 2'd0;
          idle_cnt <= 4'd0;
        end else begin
          idle_cnt <= idle_cnt + 4'd1;
        end
      end
`endif
    end
  end

endmodule
